// File: rtl/adc_pkg.sv
// adc_pkg: shared defaults and helpers for the ADC capture path.
//   DEF_BASE_ADDR        word address of the channel-0 ring
//   DEF_DEPTH            words per channel ring
//   DEF_SAMPLE_INTERVAL  clock cycles between sample ticks
//   ch_width(n)          index width for n channels, never below 1 bit
package adc_pkg;
    localparam int DEF_BASE_ADDR       = 'h800;
    localparam int DEF_DEPTH           = 640;
    localparam int DEF_SAMPLE_INTERVAL = 125000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/adc_ring_ptr.sv
// adc_ring_ptr: write index of one channel ring with wrap detection.
//   clock, reset  system clock, asynchronous active-high reset
//   adv_i         a write to this ring completes this cycle
//   ptr_o         next write index, 0..DEPTH-1
//   wrap_o        one-cycle pulse the cycle after the index wraps to 0
module adc_ring_ptr #(
    parameter int DEPTH = 640
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     adv_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o,
    output logic                     wrap_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             wrap_q, wrap_d;
    logic             last;

    assign last = ptr_q == PTR_W'(DEPTH - 1);

    always_comb begin
        ptr_d  = adv_i ? (last ? '0 : ptr_q + 1'b1) : ptr_q;
        wrap_d = adv_i && last;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;
endmodule

// File: rtl/adc_sample_writer.sv
// adc_sample_writer: round-robin ADC sample scheduler and RAM port-B writer.
//   clock, reset   system clock, asynchronous active-high reset
//   enable         tick generation enable
//   ch_data        flattened channel samples, channel c at [c*DATA_W +: DATA_W]
//   vga_prio       VGA owns port B this cycle; pending write waits
//   vga_addr       VGA read address, driven on port B when no write
//   overrun_clr    clears all sticky overrun flags
//   ram_we/addr/din  port-B write controls
//   vga_stall      port B taken by a write this cycle
//   wrap_pulse     per-channel one-cycle ring wrap pulse
//   overrun        per-channel sticky dropped-sample flag
//   wr_ptr_flat    per-channel next write index
module adc_sample_writer
    import adc_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 12,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int BASE_ADDR       = DEF_BASE_ADDR,
    parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NUM_CH*DATA_W-1:0]          ch_data,
    input  logic                              vga_prio,
    input  logic [ADDR_W-1:0]                 vga_addr,
    input  logic                              overrun_clr,
    output logic                              ram_we,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_din,
    output logic                              vga_stall,
    output logic [NUM_CH-1:0]                 wrap_pulse,
    output logic [NUM_CH-1:0]                 overrun,
    output logic [NUM_CH*$clog2(DEPTH)-1:0]   wr_ptr_flat
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SAMPLE_INTERVAL);

    if (64'(BASE_ADDR) + 64'(NUM_CH) * 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_geometry
        $error("adc_sample_writer: channel rings exceed the RAM address space");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   rr_q, rr_d, pend_ch_q, pend_ch_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [PTR_W-1:0]  ptr [NUM_CH];
    logic [PTR_W-1:0]  cur_ptr;
    logic              tick, load;

    assign tick   = enable && cnt_q == CNT_W'(SAMPLE_INTERVAL - 1);
    assign ram_we = pending_q && !vga_prio;
    // A write completing this cycle frees the slot for the tick's sample.
    assign load   = tick && (!pending_q || ram_we);

    always_comb begin
        cnt_d     = (!enable || tick) ? '0 : cnt_q + 1'b1;
        rr_d      = !tick ? rr_q : (rr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_q + 1'b1;
        pending_d = load || (pending_q && !ram_we);
        pend_ch_d = load ? rr_q : pend_ch_q;
        din_d     = load ? ch_data[rr_q*DATA_W +: DATA_W] : din_q;
        // Set wins over clear: the OR of the new flag follows the masking.
        overrun_d = (overrun_q & ~{NUM_CH{overrun_clr}}) | (NUM_CH'(tick && !load) << rr_q);
        cur_ptr   = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (pend_ch_q == CH_W'(c)) cur_ptr = ptr[c];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            rr_q      <= '0;
            pending_q <= 1'b0;
            pend_ch_q <= '0;
            din_q     <= '0;
            overrun_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            pend_ch_q <= pend_ch_d;
            din_q     <= din_d;
            overrun_q <= overrun_d;
        end
    end

    assign ram_addr  = ram_we ? ADDR_W'(BASE_ADDR) + ADDR_W'(pend_ch_q) * ADDR_W'(DEPTH) + ADDR_W'(cur_ptr)
                              : vga_addr;
    assign ram_din   = din_q;
    assign vga_stall = ram_we;
    assign overrun   = overrun_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
        adc_ring_ptr #(.DEPTH(DEPTH)) u_ptr (
            .clock  (clock),
            .reset  (reset),
            .adv_i  (ram_we && pend_ch_q == CH_W'(c)),
            .ptr_o  (ptr[c]),
            .wrap_o (wrap_pulse[c])
        );
        assign wr_ptr_flat[c*PTR_W +: PTR_W] = ptr[c];
    end
endmodule

// File: tb/tb_adc_sample_writer.sv
// tb_adc_sample_writer: directed vector bench for adc_sample_writer.
module tb_adc_sample_writer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0, vga_prio = 1'b0, overrun_clr = 1'b0;
    logic [11:0] vga_addr = 12'h123;
    logic [63:0] ch_data = {32'hB, 32'hA};
    logic        ram_we, vga_stall;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  wrap_pulse, overrun;
    logic [19:0] wr_ptr_flat;

    logic        enable_b = 1'b0, prio_b = 1'b0, clr_b = 1'b0;
    logic [11:0] vga_addr_b = 12'h0F0;
    logic [31:0] ch_data_b = 32'hC;
    logic        we_b, stall_b, wrap_b, ovr_b;
    logic [11:0] addr_b;
    logic [31:0] din_b;
    logic [1:0]  ptr_b;

    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    adc_sample_writer #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(12), .DEPTH(640), .BASE_ADDR('h800), .SAMPLE_INTERVAL(8)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .vga_prio(vga_prio), .vga_addr(vga_addr), .overrun_clr(overrun_clr),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .vga_stall(vga_stall),
        .wrap_pulse(wrap_pulse), .overrun(overrun), .wr_ptr_flat(wr_ptr_flat)
    );

    adc_sample_writer #(
        .NUM_CH(1), .DATA_W(32), .ADDR_W(12), .DEPTH(4), .BASE_ADDR('h800), .SAMPLE_INTERVAL(2)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable_b), .ch_data(ch_data_b),
        .vga_prio(prio_b), .vga_addr(vga_addr_b), .overrun_clr(clr_b),
        .ram_we(we_b), .ram_addr(addr_b), .ram_din(din_b), .vga_stall(stall_b),
        .wrap_pulse(wrap_b), .overrun(ovr_b), .wr_ptr_flat(ptr_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        bit          all;
        logic        en, prio, clr;
        logic [11:0] va;
        logic        we;
        logic [11:0] addr;
        logic [31:0] din;
        logic [1:0]  ovr;
    } vec_t;

    vec_t tbl[24];

    initial begin
        tbl[0]  = '{1,  0, 1, 0, 0, 12'h123, 0, 12'h123, 32'h0, 2'b00};
        tbl[1]  = '{7,  1, 1, 0, 0, 12'h123, 0, 12'h123, 32'h0, 2'b00};
        tbl[2]  = '{1,  0, 1, 0, 0, 12'h123, 1, 12'h800, 32'hA, 2'b00};
        tbl[3]  = '{1,  0, 1, 0, 0, 12'h123, 0, 12'h123, 32'hA, 2'b00};
        tbl[4]  = '{6,  1, 1, 0, 0, 12'h123, 0, 12'h123, 32'hA, 2'b00};
        tbl[5]  = '{1,  0, 1, 0, 0, 12'h123, 1, 12'hA80, 32'hB, 2'b00};
        tbl[6]  = '{8,  0, 1, 0, 0, 12'h123, 1, 12'h801, 32'hA, 2'b00};
        tbl[7]  = '{7,  1, 1, 1, 0, 12'h456, 0, 12'h456, 32'hA, 2'b00};
        tbl[8]  = '{1,  0, 1, 1, 0, 12'h456, 0, 12'h456, 32'hB, 2'b00};
        tbl[9]  = '{7,  1, 1, 1, 0, 12'h456, 0, 12'h456, 32'hB, 2'b00};
        tbl[10] = '{1,  0, 1, 1, 0, 12'h456, 0, 12'h456, 32'hB, 2'b01};
        tbl[11] = '{4,  1, 1, 1, 0, 12'h456, 0, 12'h456, 32'hB, 2'b01};
        tbl[12] = '{1,  0, 1, 0, 0, 12'h123, 1, 12'hA81, 32'hB, 2'b01};
        tbl[13] = '{1,  0, 1, 0, 0, 12'h123, 0, 12'h123, 32'hB, 2'b01};
        tbl[14] = '{2,  0, 1, 0, 0, 12'h123, 1, 12'hA82, 32'hB, 2'b01};
        tbl[15] = '{8,  0, 1, 0, 0, 12'h123, 1, 12'h802, 32'hA, 2'b01};
        tbl[16] = '{1,  0, 1, 0, 1, 12'h123, 0, 12'h123, 32'hA, 2'b01};
        tbl[17] = '{1,  0, 1, 0, 0, 12'h123, 0, 12'h123, 32'hA, 2'b00};
        tbl[18] = '{12, 0, 1, 1, 0, 12'h456, 0, 12'h456, 32'hB, 2'b00};
        tbl[19] = '{1,  0, 1, 1, 1, 12'h456, 0, 12'h456, 32'hB, 2'b00};
        tbl[20] = '{1,  0, 1, 0, 0, 12'h123, 1, 12'hA83, 32'hB, 2'b01};
        tbl[21] = '{24, 1, 0, 0, 0, 12'h123, 0, 12'h123, 32'hB, 2'b01};
        tbl[22] = '{8,  0, 1, 0, 0, 12'h123, 0, 12'h123, 32'hB, 2'b01};
        tbl[23] = '{1,  0, 1, 0, 0, 12'h123, 1, 12'hA84, 32'hB, 2'b01};

        repeat (3) @(negedge clock);
        #1;
        chk("reset we", ram_we, 0);
        chk("reset addr", ram_addr, 12'h123);
        chk("reset din", ram_din, 0);
        chk("reset ovr", overrun, 0);
        chk("reset ptr", wr_ptr_flat, 0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                @(negedge clock);
                enable = tbl[i].en;
                vga_prio = tbl[i].prio;
                overrun_clr = tbl[i].clr;
                vga_addr = tbl[i].va;
                #1;
                if (tbl[i].all || j == tbl[i].n - 1) begin
                    chk($sformatf("row%0d.%0d we", i, j), ram_we, tbl[i].we);
                    chk($sformatf("row%0d.%0d stall", i, j), vga_stall, tbl[i].we);
                    chk($sformatf("row%0d.%0d addr", i, j), ram_addr, tbl[i].addr);
                    chk($sformatf("row%0d.%0d din", i, j), ram_din, tbl[i].din);
                    chk($sformatf("row%0d.%0d ovr", i, j), overrun, tbl[i].ovr);
                    chk($sformatf("row%0d.%0d wrap", i, j), wrap_pulse, 0);
                end
            end
        end
        overrun_clr = 1'b0;

        @(negedge clock);
        vga_prio = 1'b1;
        vga_addr = 12'h456;
        #1;
        chk("ptr flat", wr_ptr_flat, {10'd5, 10'd3});
        repeat (6) @(negedge clock);
        @(negedge clock);
        #1;
        chk("held we", ram_we, 0);
        chk("held din", ram_din, 32'hA);
        reset = 1'b1;
        vga_prio = 1'b0;
        #1;
        chk("rst we", ram_we, 0);
        chk("rst addr", ram_addr, 12'h456);
        chk("rst din", ram_din, 0);
        chk("rst ovr", overrun, 0);
        chk("rst ptr", wr_ptr_flat, 0);
        repeat (2) @(negedge clock);
        #1;
        chk("rst hold we", ram_we, 0);
        reset = 1'b0;
        enable = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            enable = 1'b1;
            #1;
            chk($sformatf("post rst %0d we", k), ram_we, k == 8);
            if (k == 8) begin
                chk("post rst addr", ram_addr, 12'h800);
                chk("post rst din", ram_din, 32'hA);
            end
        end

        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            enable_b = 1'b1;
            #1;
            chk($sformatf("ring %0d we", k), we_b, k >= 2 && k % 2 == 0);
            chk($sformatf("ring %0d addr", k), addr_b,
                (k >= 2 && k % 2 == 0) ? 12'(12'h800 + (k / 2 - 1) % 4) : 12'h0F0);
            chk($sformatf("ring %0d wrap", k), wrap_b, k == 9);
            if (k == 2) chk("ring din", din_b, 32'hC);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_writer.md
# adc_sample_writer

Parametrised sample scheduler and RAM port‑B writer for the ADC capture path. Samples NUM_CH channels round‑robin at a fixed interval, stores each channel into its own circular buffer in data RAM, and time‑shares RAM port B with the VGA reader. Adds deferred writes under VGA priority, per‑channel wrap pulses and sticky overrun flags. Sits between the ADC capture block, the VGA controller and RAM port B in the top‑level wrapper.

## Interface
- NUM_CH, 2: number of channels, ≥1
- DATA_W, 32: sample word width
- ADDR_W, 12: RAM word‑address width
- DEPTH, 640: words per channel ring, ≥2
- BASE_ADDR, 12'h800: word address of channel 0 ring; channel c base = BASE_ADDR + c*DEPTH
- SAMPLE_INTERVAL, 125000: clock cycles between ticks, ≥2
- clock  in  1  system clock
- reset  in  1  asynchronous, active‑high
- enable  in  1  tick generation enable
- ch_data  in  NUM_CH*DATA_W  flattened samples, channel c at [c*DATA_W +: DATA_W]
- vga_prio  in  1  VGA claims port B this cycle; defers writes
- vga_addr  in  ADDR_W  VGA read address
- overrun_clr  in  1  clears all overrun flags
- ram_we  out  1  port‑B write enable
- ram_addr  out  ADDR_W  port‑B address
- ram_din  out  DATA_W  port‑B write data
- vga_stall  out  1  port B taken by a write; VGA read data invalid next cycle
- wrap_pulse  out  NUM_CH  one‑cycle pulse when channel ring wraps
- overrun  out  NUM_CH  sticky: a tick found the write slot still occupied
- wr_ptr_flat  out  NUM_CH*$clog2(DEPTH)  next write index per channel

## Operation
- Interval counter: 0..SAMPLE_INTERVAL‑1 while enable; held at 0 while !enable. tick = enable && counter==SAMPLE_INTERVAL‑1.
- Round‑robin index rr: advances on every tick, wraps NUM_CH‑1 → 0.
- On tick: if slot free (or being freed this cycle), latch ch_data[rr] into ram_din, pend_ch ← rr, pending ← 1. If slot occupied and not freed: sample dropped, overrun[rr] ← 1, pending data unchanged; rr still advances.
- Write: ram_we = pending && !vga_prio (combinational). ram_addr = ram_we ? BASE_ADDR + pend_ch*DEPTH + ptr[pend_ch] : vga_addr. vga_stall = ram_we.
- End of write cycle: pending ← 0; ptr[pend_ch] ← ptr==DEPTH‑1 ? 0 : ptr+1; on wrap, wrap_pulse[pend_ch] high the following cycle for exactly one cycle.
- overrun_clr clears all flags; set in the same cycle wins.
- Disabling stops new ticks only; a pending write still drains.
- Address arithmetic in ADDR_W bits; elaboration error if BASE_ADDR + NUM_CH*DEPTH > 2**ADDR_W.

## Timing
- Reset values: counter 0, rr 0, pending 0, pend_ch 0, all ptr 0, overrun 0, wrap_pulse 0, ram_din 0; hence ram_we 0, vga_stall 0, ram_addr = vga_addr.
- Reset mid‑operation drops any pending sample; no write issues in the reset cycle.
- Latency: ch_data sampled at the tick edge; ram_we high in the next cycle if vga_prio low; otherwise first cycle with vga_prio low.
- Tick coinciding with the completing write cycle: not an overrun; new sample loads.
- Back‑to‑back wrap not possible (SAMPLE_INTERVAL ≥ 2).
- Tick period exactly SAMPLE_INTERVAL cycles; each channel serviced every NUM_CH*SAMPLE_INTERVAL cycles.

## Structure
- Shared package adc_pkg: default BASE_ADDR, DEPTH, SAMPLE_INTERVAL, and channel‑index width function ($clog2 with floor of 1).
- One sub‑module adc_ring_ptr (per‑channel pointer, wrap detect, wrap_pulse register), instantiated NUM_CH times via generate.

## Test plan
- SAMPLE_INTERVAL=8, NUM_CH=2, vga_prio=0, ch0=0xA, ch1=0xB -> writes alternate at addr 0x800 (0xA), 0x280+0x800=0xA80 (0xB), ticks 8 cycles apart, ram_we one cycle each.
- DEPTH=4, one channel → after 4 ch0 writes, addresses 0x800..0x803, wrap_pulse[0] one cycle after 4th write, 5th write to 0x800.
- vga_prio held high 20 cycles spanning a tick -> ram_addr follows vga_addr, write issues first cycle vga_prio drops; hold past next tick -> overrun[ch] set, second sample absent from RAM.
- overrun_clr and new overrun same cycle -> overrun stays 1; overrun_clr alone -> 0.
- reset asserted with pending=1 -> no write, all outputs at reset values, first post‑reset write to 0x800.
- enable low 3 intervals then high -> no writes while low, first tick SAMPLE_INTERVAL cycles after enable rises, rr continues from saved value.
